// File: rtl/secuenciador_itr_pkg.sv
// Shared types and constants for the ITR instruction sequencer.
package secuenciador_itr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int         OPCODE_HI   = 31;
  localparam int         OPCODE_LO   = 26;
  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  // True when the instruction word carries the halt opcode.
  function automatic logic is_halt(input logic [31:0] word);
    return word[OPCODE_HI:OPCODE_LO] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/secuenciador_itr.sv
// Multi-cycle sequencer: fetches words from a synchronous ROM, holds each on
// itr for HOLD_CYCLES cycles, samples the datapath zero flag, and counts.
//
// Handshake: im_rd is a one-cycle read request for im_addr; the memory
// presents the word on im_data in the following cycle (no back-pressure).
// itr is meaningful to the datapath only while itr_valid is high.
// All outputs are flops whose next value is derived from the next state.
module secuenciador_itr
  import secuenciador_itr_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic [ADDR_W-1:0] prog_last,
  output logic [ADDR_W-1:0] im_addr,
  output logic              im_rd,
  input  logic [31:0]       im_data,
  output logic [31:0]       itr,
  output logic              itr_valid,
  input  logic              tr_zf,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   retired,
  output logic [ADDR_W:0]   zf_count,
  output state_e            dbg_state
);

  localparam int              HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [ADDR_W:0]     retired_q, retired_d;
  logic [ADDR_W:0]     zf_count_q, zf_count_d;
  logic [31:0]         itr_q, itr_d;
  logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
  logic                im_rd_q, im_rd_d;
  logic                itr_valid_q, itr_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                exec_sample;

  // The final EXEC cycle of an instruction: flag sampled, counters updated.
  assign exec_sample = (state_q == ST_EXEC) && !pause && (hold_q == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: start only matters in IDLE, pause only in FETCH/EXEC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: if (!pause) state_d = ST_LOAD;
      ST_LOAD:  state_d = is_halt(im_data) ? ST_DONE : ST_EXEC;
      ST_EXEC:  if (exec_sample) state_d = (pc_q == last_q) ? ST_DONE : ST_FETCH;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Program counter, hold counter, statistics and the captured instruction.
  always_comb begin
    pc_d       = pc_q;
    last_d     = last_q;
    hold_d     = hold_q;
    retired_d  = retired_q;
    zf_count_d = zf_count_q;
    itr_d      = itr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          last_d     = prog_last;
          pc_d       = '0;
          retired_d  = '0;
          zf_count_d = '0;
        end
      end
      ST_LOAD: begin
        itr_d = im_data;
        if (!is_halt(im_data)) hold_d = HOLD_INIT;
      end
      ST_EXEC: begin
        if (!pause) begin
          if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
          end else begin
            retired_d  = retired_q + (ADDR_W+1)'(1);
            zf_count_d = zf_count_q + {{ADDR_W{1'b0}}, tr_zf};
            if (pc_q != last_q) pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs follow the state being entered.
  always_comb begin
    im_rd_d     = (state_d == ST_FETCH);
    im_addr_d   = (state_d == ST_FETCH) ? pc_d : im_addr_q;
    itr_valid_d = (state_d == ST_EXEC);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  // Datapath and output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= '0;
      last_q      <= '0;
      hold_q      <= '0;
      retired_q   <= '0;
      zf_count_q  <= '0;
      itr_q       <= '0;
      im_addr_q   <= '0;
      im_rd_q     <= 1'b0;
      itr_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      retired_q   <= retired_d;
      zf_count_q  <= zf_count_d;
      itr_q       <= itr_d;
      im_addr_q   <= im_addr_d;
      im_rd_q     <= im_rd_d;
      itr_valid_q <= itr_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign im_addr   = im_addr_q;
  assign im_rd     = im_rd_q;
  assign itr       = itr_q;
  assign itr_valid = itr_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign retired   = retired_q;
  assign zf_count  = zf_count_q;
  assign dbg_state = state_q;

endmodule
